// File: rtl/serial_frame_rx.sv
// Serial frame deframer: start / DATA_W data bits (LSB first) / optional parity / stop.
// Define PARITY_EN to include the even-parity bit and ParityErr checking.
`timescale 1ns / 1ps

module serial_frame_rx #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IDLE_MIN = 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              SerIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              FrameErr,
    output logic              ParityErr,
    output logic              Overrun,
    output logic              Busy
);

    // The ones-counter leaves ARM on the sample that reaches IDLE_MIN, so it never exceeds IDLE_MIN-1.
    localparam int unsigned OnesW = (IDLE_MIN > 1) ? $clog2(IDLE_MIN) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [OnesW-1:0] OnesLast = OnesW'(IDLE_MIN - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StData,
`ifdef PARITY_EN
        StParity,
`endif
        StStop
    } state_t;

    state_t            state;
    logic [OnesW-1:0]  onesCnt;
    logic [BitW-1:0]   bitCnt;
    logic [DATA_W-1:0] shiftReg;
    logic              parityOk;
    logic              goodStop;

`ifdef PARITY_EN
    logic parityBit;
    assign parityOk = ~^{shiftReg, parityBit};
`else
    assign parityOk  = 1'b1;
    assign ParityErr = 1'b0;
`endif

    assign goodStop = SerIn & parityOk;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= StArm;
            onesCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            FrameErr  <= 1'b0;
            Overrun   <= 1'b0;
`ifdef PARITY_EN
            parityBit <= 1'b0;
            ParityErr <= 1'b0;
`endif
        end else begin
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
`ifdef PARITY_EN
            ParityErr <= 1'b0;
`endif
            // A word loaded in STOP below overrides this consume.
            if (DataValid && DataReady) begin
                DataValid <= 1'b0;
            end

            case (state)
                StArm: begin
                    if (!SerIn) begin
                        onesCnt <= '0;
                    end else if (onesCnt == OnesLast) begin
                        onesCnt <= '0;
                        state   <= StIdle;
                    end else begin
                        onesCnt <= onesCnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (!SerIn) begin
                        bitCnt <= '0;
                        state  <= StData;
                    end
                end
                StData: begin
                    shiftReg[bitCnt] <= SerIn;
                    bitCnt           <= bitCnt + 1'b1;
                    if (bitCnt == BitLast) begin
`ifdef PARITY_EN
                        state <= StParity;
`else
                        state <= StStop;
`endif
                    end
                end
`ifdef PARITY_EN
                StParity: begin
                    parityBit <= SerIn;
                    state     <= StStop;
                end
`endif
                StStop: begin
                    FrameErr <= ~SerIn;
`ifdef PARITY_EN
                    ParityErr <= ~parityOk;
`endif
                    if (goodStop) begin
                        if (!DataValid || DataReady) begin
                            DataOut   <= shiftReg;
                            DataValid <= 1'b1;
                        end else begin
                            Overrun <= 1'b1;
                        end
                    end
                    // A 0 stop bit means we lost sync: require a fresh idle run.
                    state <= SerIn ? StIdle : StArm;
                end
                default: state <= StArm;
            endcase
        end
    end

`ifdef PARITY_EN
    assign Busy = (state == StData) || (state == StParity) || (state == StStop);
`else
    assign Busy = (state == StData) || (state == StStop);
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed test-plan steps followed by random frames,
// checked every cycle against a frame-position reference model.
`timescale 1ns / 1ps

module tb_serial_frame_rx;

    localparam int DW = 8;
    localparam int IM = 2;
`ifdef PARITY_EN
    localparam bit ParOn = 1'b1;
`else
    localparam bit ParOn = 1'b0;
`endif

    logic          Clock     = 1'b0;
    logic          Reset_n   = 1'b0;
    logic          SerIn     = 1'b0;
    logic          DataReady = 1'b0;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          FrameErr;
    logic          ParityErr;
    logic          Overrun;
    logic          Busy;

    serial_frame_rx #(
        .DATA_W   (DW),
        .IDLE_MIN (IM)
    ) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .SerIn     (SerIn),
        .DataOut   (DataOut),
        .DataValid (DataValid),
        .DataReady (DataReady),
        .FrameErr  (FrameErr),
        .ParityErr (ParityErr),
        .Overrun   (Overrun),
        .Busy      (Busy)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the current frame (-1 = between frames).
    bit            mArmed;
    int            mOnes;
    int            mPos;
    logic [DW-1:0] mWord;
    logic          mPar;
    logic          mValid;
    logic [DW-1:0] mData;
    logic          eFe;
    logic          ePe;
    logic          eOv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string where);
        chk({where, ":DataValid"}, 32'(DataValid), 32'(mValid));
        chk({where, ":DataOut"},   32'(DataOut),   32'(mData));
        chk({where, ":FrameErr"},  32'(FrameErr),  32'(eFe));
        chk({where, ":ParityErr"}, 32'(ParityErr), 32'(ePe));
        chk({where, ":Overrun"},   32'(Overrun),   32'(eOv));
        chk({where, ":Busy"},      32'(Busy),      32'(mPos >= 0));
    endtask

    task automatic modelReset();
        mArmed = 1'b0;
        mOnes  = 0;
        mPos   = -1;
        mWord  = '0;
        mPar   = 1'b0;
        mValid = 1'b0;
        mData  = '0;
        eFe    = 1'b0;
        ePe    = 1'b0;
        eOv    = 1'b0;
    endtask

    task automatic step(input logic s, input logic r, input string tag);
        logic good;
        logic parOk;
        SerIn     = s;
        DataReady = r;
        @(posedge Clock);
        #1;
        eFe  = 1'b0;
        ePe  = 1'b0;
        eOv  = 1'b0;
        good = 1'b0;
        if (mPos < 0) begin
            if (mArmed) begin
                if (!s) mPos = 0;
            end else begin
                mOnes = s ? mOnes + 1 : 0;
                if (mOnes >= IM) begin
                    mArmed = 1'b1;
                    mOnes  = 0;
                end
            end
        end else begin
            mPos++;
            if (mPos <= DW) begin
                mWord = {s, mWord[DW-1:1]};
            end else if (ParOn && mPos == DW + 1) begin
                mPar = s;
            end else begin
                parOk  = !ParOn || ((^mWord) == mPar);
                eFe    = !s;
                ePe    = !parOk;
                good   = s && parOk;
                mArmed = s;
                mOnes  = 0;
                mPos   = -1;
            end
        end
        if (good) begin
            if (!mValid || r) begin
                mData  = mWord;
                mValid = 1'b1;
            end else begin
                eOv = 1'b1;
            end
        end else if (mValid && r) begin
            mValid = 1'b0;
        end
        checkAll(tag);
    endtask

    function automatic logic evenPar(input logic [DW-1:0] d);
        return ^d;
    endfunction

    task automatic sendFrame(input logic [DW-1:0] d, input logic par, input logic stop,
                             input logic rdy, input logic rdyStop, input string tag);
        step(1'b0, rdy, tag);
        for (int i = 0; i < DW; i++) step(d[i], rdy, tag);
        if (ParOn) step(par, rdy, tag);
        step(stop, rdyStop, tag);
    endtask

    task automatic doReset(input string tag);
        Reset_n = 1'b0;
        #2;
        modelReset();
        chk({tag, ":DataValid_async"}, 32'(DataValid), 32'(0));
        chk({tag, ":Busy_async"},      32'(Busy),      32'(0));
        #2;
        Reset_n = 1'b1;
        checkAll({tag, ":released"});
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          par;
        logic          stop;
        int            gap;
        modelReset();
        #12;
        Reset_n = 1'b1;
        checkAll("reset");

        repeat (10) step(1'b0, 1'b0, "arm_zeros");

        step(1'b1, 1'b1, "idle_run");
        step(1'b1, 1'b1, "idle_run");
        sendFrame(8'hA5, evenPar(8'hA5), 1'b1, 1'b1, 1'b1, "frame_a5");
        step(1'b1, 1'b1, "a5_consumed");

        // Holding register full: second word overruns.
        step(1'b1, 1'b0, "gap");
        sendFrame(8'h3C, evenPar(8'h3C), 1'b1, 1'b0, 1'b0, "ovr_first");
        sendFrame(8'hC3, evenPar(8'hC3), 1'b1, 1'b0, 1'b0, "ovr_second");
        step(1'b1, 1'b1, "ovr_drain");
        step(1'b1, 1'b0, "gap");

        // Ready exactly on the second stop edge: replace, no overrun.
        sendFrame(8'h3C, evenPar(8'h3C), 1'b1, 1'b0, 1'b0, "rdy_first");
        sendFrame(8'hC3, evenPar(8'hC3), 1'b1, 1'b0, 1'b1, "rdy_second");
        step(1'b1, 1'b1, "rdy_drain");

        // Framing error, then a start preceded by a single 1 is ignored.
        sendFrame(8'h55, evenPar(8'h55), 1'b0, 1'b0, 1'b0, "frame_err");
        step(1'b1, 1'b0, "one_only");
        step(1'b0, 1'b0, "lone_start");
        step(1'b1, 1'b0, "rearm");
        step(1'b1, 1'b0, "rearm");
        sendFrame(8'h01, evenPar(8'h01), 1'b1, 1'b0, 1'b1, "frame_01");
        step(1'b1, 1'b1, "f01_consumed");

        // Reset during data bit 4.
        step(1'b0, 1'b0, "part_start");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "part_data");
        doReset("mid_reset");
        step(1'b1, 1'b0, "post_reset_idle");
        step(1'b1, 1'b0, "post_reset_idle");
        sendFrame(8'hFF, evenPar(8'hFF), 1'b1, 1'b0, 1'b0, "frame_ff");
        step(1'b1, 1'b1, "ff_consumed");

`ifdef PARITY_EN
        sendFrame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0, "par_good");
        step(1'b1, 1'b1, "par_consumed");
        sendFrame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, "par_bad");
        sendFrame(8'h07, 1'b0, 1'b0, 1'b0, 1'b0, "par_bad_stop0");
        step(1'b1, 1'b0, "par_rearm");
        step(1'b1, 1'b0, "par_rearm");
`endif

        // Random frames with occasional parity/stop errors, short gaps and random ready.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 39) == 0) doReset("rnd_reset");
            gap = $urandom_range(0, 3);
            repeat (gap) step(1'b1, 1'($urandom_range(0, 1)), "rnd_gap");
            d    = DW'($urandom);
            par  = evenPar(d) ^ ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 7) != 0);
            step(1'b0, 1'($urandom_range(0, 1)), "rnd_start");
            for (int i = 0; i < DW; i++) step(d[i], 1'($urandom_range(0, 1)), "rnd_data");
            if (ParOn) step(par, 1'($urandom_range(0, 1)), "rnd_par");
            step(stop, 1'($urandom_range(0, 1)), "rnd_stop");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

- Downstream consumer of the registered single-bit stream produced by the inverting D flip-flop stage.
- Deframes the stream, one bit per Clock, into start / DATA_W data bits (LSB first) / optional parity / stop frames.
- Presents each good word on a one-entry valid/ready output register.
- Flags framing, parity and overrun errors.
- Because the upstream flop resets to 0, the block must see a run of idle 1s before it accepts a start bit.

## Interface
- DATA_W, 8: data bits per frame; legal range 1..16.
- IDLE_MIN, 2: consecutive 1 samples required before a start bit is accepted; minimum 1.

- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- SerIn  in  1  serial stream, sampled every rising edge of Clock.
- DataOut  out  DATA_W  received word; reset 0.
- DataValid  out  1  DataOut holds an unconsumed word; reset 0.
- DataReady  in  1  consumer accepts the word when sampled high with DataValid.
- FrameErr  out  1  one-cycle pulse: stop bit sampled 0; reset 0.
- ParityErr  out  1  one-cycle pulse: parity mismatch; reset 0.
- Overrun  out  1  one-cycle pulse: good word dropped because the holding register was full; reset 0.
- Busy  out  1  FSM is in DATA, PARITY or STOP; reset 0.

## Operation
- The FSM has five states: ARM, IDLE, DATA, PARITY, STOP. Reset enters ARM with the ones-counter at 0.
- ARM:
  - SerIn=1 increments the ones-counter.
  - SerIn=0 clears the counter.
  - When the counter reaches IDLE_MIN, go to IDLE.
  - The counter saturates and is cleared on leaving ARM.
- IDLE: SerIn=0 is the start bit: go to DATA with the bit counter at 0. SerIn=1 stays in IDLE.
- DATA:
  - Each sample shifts into the shift register at index bit-count, so the first data bit becomes the LSB.
  - After DATA_W samples, go to PARITY if it is compiled in; otherwise go to STOP.
- PARITY: sample the parity bit and go to STOP.
- STOP: sample the stop bit.
  - SerIn=1 and parity OK: the word is good; go to IDLE.
  - SerIn=0: FrameErr pulses, the word is discarded, go to ARM. A full IDLE_MIN run of 1s is needed again.
  - Parity bad: ParityErr pulses and the word is discarded. If the stop bit is 1, go to IDLE; otherwise go to ARM. A bad parity bit and a 0 stop bit pulse both flags.
- A good word is loaded at the STOP edge:
  - If DataValid=0, or DataValid=1 and DataReady=1 on that edge, load DataOut and set DataValid=1.
  - Otherwise keep the old DataOut, pulse Overrun, and drop the new word.
- Handshake:
  - DataValid stays high and DataOut stays stable until an edge with DataValid=1 and DataReady=1.
  - On that edge DataValid clears, unless a good word loads on the same edge; then it stays 1 with the new data.
- DataReady is ignored while DataValid=0.
- Busy is a combinational decode of the state.

## Timing
- All outputs are registered except Busy.
- If the start bit is sampled at edge k:
  - Data bits are sampled at edges k+1 .. k+DATA_W.
  - Without parity, the stop bit is sampled at edge k+DATA_W+1.
  - With parity, the parity bit is sampled at k+DATA_W+1 and the stop bit at k+DATA_W+2.
- DataValid, FrameErr, ParityErr and Overrun update at the stop-sample edge. They are visible in the following cycle.
- Back-to-back frames are supported with no idle gap: a start bit may be sampled on the edge right after a good stop.
- Minimum frame period is DATA_W+2 cycles (DATA_W+3 with parity).
- Reset_n low at any time, mid-frame included:
  - Asynchronously return to ARM.
  - Clear DataValid, DataOut and all counters.
  - Drop any partial frame.

## Configuration
- PARITY_EN defined:
  - PARITY state present; even parity over the data bits plus the parity bit.
  - ParityErr behaves as specified in Operation.
- PARITY_EN undefined:
  - No PARITY state; STOP directly follows DATA.
  - ParityErr stays as a port, tied to 0.

## Test plan
DATA_W=8, IDLE_MIN=2 unless noted.
- Reset then SerIn=0 for 10 cycles -> stays in ARM; DataValid=0; Busy=0; no error pulses.
- SerIn 1,1 then frame 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB first, stop), DataReady=1 -> DataOut=0xA5 and DataValid=1 at start-edge+9; cleared one cycle later.
- Two back-to-back frames 0x3C then 0xC3 with DataReady=0 -> DataOut stays 0x3C; Overrun pulses once at the second stop edge. Repeat with DataReady=1 pulsed exactly on the second stop edge -> DataOut=0xC3, DataValid stays 1, no Overrun.
- Frame 0x55 with stop bit 0 -> FrameErr one-cycle pulse; DataValid unchanged. A following start bit preceded by only one 1 is ignored; after two 1s, frame 0x01 is received correctly.
- Reset_n pulsed low during data bit 4 -> DataValid=0, Busy=0 immediately. The next valid frame 0xFF after two 1s is received correctly.
- PARITY_EN: frame 0x07 with parity 1 -> good, DataOut=0x07. Frame 0x07 with parity 0 -> ParityErr pulse, no load. Parity 0 and stop 0 -> ParityErr and FrameErr pulse together, FSM returns to ARM.
